program_loader: RTL and testbench

Write-side counterpart to the controller's opcode fetch path. It accepts a stream of program bytes over a valid/ready handshake and writes them into consecutive register_file locations, starting at address 0. It holds op low while loading, so memory addressing stays on the user/loader side. After the last word it raises op, handing memory to the controller for execution.

---
 rtl/program_loader_if.sv | 22 ++
 rtl/program_loader.sv | 144 ++++++++++++++
 tb/tb_program_loader.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// Host byte stream and register_file write port of the program loader.
interface program_loader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  data_valid;
    logic                  data_ready;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  mem_wr;

    modport slave (
        input  data_in, data_valid,
        output data_ready, mem_address, mem_data, mem_wr
    );

    modport master (
        output data_in, data_valid,
        input  data_ready, mem_address, mem_data, mem_wr
    );
endinterface

// File: rtl/program_loader.sv
// Loads PROG_LEN program words into register_file from address 0, then hands memory to the controller.
// Optional trailing checksum byte check is enabled with LOADER_CHECKSUM_EN.
module program_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int PROG_LEN   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  halt,
    program_loader_if.slave       bus,
    output logic                  op,
    output logic                  loading,
    output logic                  done,
`ifdef LOADER_CHECKSUM_EN
    output logic                  checksum_err,
`endif
    output logic [ADDR_WIDTH:0]   word_count
);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, LOAD, CHECK, RUN} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, RUN} state_t;
`endif

    localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH+1)'(PROG_LEN - 1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
    logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
    logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
    logic                  mem_wr_q, mem_wr_d;
    logic                  xfer;
`ifdef LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_q, sum_d;
    logic                  err_q, err_d;

    function automatic logic [DATA_WIDTH-1:0] checksum_add(
        input logic [DATA_WIDTH-1:0] acc,
        input logic [DATA_WIDTH-1:0] b
    );
        return acc + b;
    endfunction

    // The trailing checksum byte is accepted in CHECK but never written.
    assign bus.data_ready = (state_q == LOAD) || (state_q == CHECK);
    assign checksum_err   = err_q;
`else
    assign bus.data_ready = (state_q == LOAD);
`endif

    assign xfer        = bus.data_valid && bus.data_ready;
    assign op          = (state_q == RUN);
    assign done        = (state_q == RUN);
    assign loading     = (state_q == LOAD);
    assign word_count  = word_count_q;
    assign bus.mem_address = mem_address_q;
    assign bus.mem_data    = mem_data_q;
    assign bus.mem_wr      = mem_wr_q;

    always_comb begin
        state_d       = state_q;
        word_count_d  = word_count_q;
        mem_address_d = mem_address_q;
        mem_data_d    = mem_data_q;
        mem_wr_d      = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        sum_d         = sum_q;
        err_d         = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = LOAD;
                    word_count_d = '0;
`ifdef LOADER_CHECKSUM_EN
                    sum_d        = '0;
                    err_d        = 1'b0;
`endif
                end
            end
            LOAD: begin
                if (xfer) begin
                    mem_data_d    = bus.data_in;
                    mem_address_d = word_count_q[ADDR_WIDTH-1:0];
                    mem_wr_d      = 1'b1;
                    word_count_d  = word_count_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    sum_d         = checksum_add(sum_q, bus.data_in);
                    if (word_count_q == LAST_IDX) state_d = CHECK;
`else
                    if (word_count_q == LAST_IDX) state_d = FLUSH;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                if (xfer) begin
                    if (bus.data_in == sum_q) begin
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
`else
            // One quiet cycle so the final write retires before the controller takes memory.
            FLUSH: state_d = RUN;
`endif
            RUN: begin
                if (halt) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            word_count_q  <= '0;
            mem_address_q <= '0;
            mem_data_q    <= '0;
            mem_wr_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q         <= '0;
            err_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            word_count_q  <= word_count_d;
            mem_address_q <= mem_address_d;
            mem_data_q    <= mem_data_d;
            mem_wr_q      <= mem_wr_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q         <= sum_d;
            err_q         <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: a 16-word instance and a 4-word instance share one stimulus path.
module tb_program_loader;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int LEN_F = 16;
    localparam int LEN_S = 4;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [31:0]   c;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    logic sel, start, halt, dv;
    logic [DW-1:0] din;
    logic [31:0] cyc = 0;
    int checks = 0;
    int errors = 0;
    int cnt_f = 0;
    int cnt_s = 0;
    wr_t q_f[$];
    wr_t q_s[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    program_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_f ();
    program_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_s ();

    assign bus_f.data_valid = dv & ~sel;
    assign bus_f.data_in    = din;
    assign bus_s.data_valid = dv & sel;
    assign bus_s.data_in    = din;

    logic op_f, ld_f, dn_f, op_s, ld_s, dn_s;
    logic [AW:0] wc_f, wc_s;
`ifdef LOADER_CHECKSUM_EN
    logic ce_f, ce_s;
`endif

    program_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PROG_LEN(LEN_F)) u_full (
        .clk(clk), .reset(reset), .start(start & ~sel), .halt(halt & ~sel),
        .bus(bus_f.slave), .op(op_f), .loading(ld_f), .done(dn_f),
`ifdef LOADER_CHECKSUM_EN
        .checksum_err(ce_f),
`endif
        .word_count(wc_f)
    );

    program_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PROG_LEN(LEN_S)) u_short (
        .clk(clk), .reset(reset), .start(start & sel), .halt(halt & sel),
        .bus(bus_s.slave), .op(op_s), .loading(ld_s), .done(dn_s),
`ifdef LOADER_CHECKSUM_EN
        .checksum_err(ce_s),
`endif
        .word_count(wc_s)
    );

    logic rdy, op_m, ld_m, dn_m;
    logic [AW:0] wc_m;
    assign rdy  = sel ? bus_s.data_ready : bus_f.data_ready;
    assign op_m = sel ? op_s : op_f;
    assign ld_m = sel ? ld_s : ld_f;
    assign dn_m = sel ? dn_s : dn_f;
    assign wc_m = sel ? wc_s : wc_f;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic check_wr(input string nm, input wr_t e, input logic [AW-1:0] a, input logic [DW-1:0] d);
        check({nm, "_addr"}, 32'(a), 32'(e.a));
        check({nm, "_data"}, 32'(d), 32'(e.d));
        check({nm, "_cycle"}, cyc, e.c);
    endtask

    always @(negedge clk) begin
        if (!reset && bus_f.mem_wr) begin
            if (q_f.size() == 0) begin
                checks++; errors++;
                $display("FAIL full_unexpected_wr addr=%0h data=%0h required no write", bus_f.mem_address, bus_f.mem_data);
            end else check_wr("full_wr", q_f.pop_front(), bus_f.mem_address, bus_f.mem_data);
        end
    end

    always @(negedge clk) begin
        if (!reset && bus_s.mem_wr) begin
            if (q_s.size() == 0) begin
                checks++; errors++;
                $display("FAIL short_unexpected_wr addr=%0h data=%0h required no write", bus_s.mem_address, bus_s.mem_data);
            end else check_wr("short_wr", q_s.pop_front(), bus_s.mem_address, bus_s.mem_data);
        end
    end

    // Present one byte from a falling edge; returns on the falling edge after it was taken.
    task automatic send(input logic [DW-1:0] b, input bit push);
        int n = 0;
        wr_t e;
        dv = 1'b1; din = b;
        while (!rdy && n < 40) begin
            @(negedge clk); n++;
        end
        if (!rdy) begin
            checks++; errors++;
            $display("FAIL send_timeout byte=%0h ready=0 required ready=1", b);
            dv = 1'b0;
            return;
        end
        if (push) begin
            e.d = b;
            e.c = cyc + 1;
            if (sel) begin e.a = AW'(cnt_s); cnt_s++; q_s.push_back(e); end
            else     begin e.a = AW'(cnt_f); cnt_f++; q_f.push_back(e); end
        end
        @(negedge clk);
        dv = 1'b0;
    endtask

    task automatic idle();
        dv = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_load(input logic [DW-1:0] sum, input int len);
`ifdef LOADER_CHECKSUM_EN
        send(sum, 1'b0);
        check("run_done", 32'(dn_m), 1);
        check("run_cksum_err", 32'(sel ? ce_s : ce_f), 0);
`else
        check("flush_done", 32'(dn_m), 0);
        check("flush_ready", 32'(rdy), 0);
        @(negedge clk);
        check("run_done", 32'(dn_m), 1);
`endif
        check("run_op", 32'(op_m), 1);
        check("run_ready", 32'(rdy), 0);
        check("run_word_count", 32'(wc_m), 32'(len));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired required finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; sel = 1'b0; start = 1'b0; halt = 1'b0; dv = 1'b0; din = '0;
        repeat (2) @(negedge clk);
        check("rst_op", 32'(op_f | op_s), 0);
        check("rst_done", 32'(dn_f | dn_s), 0);
        check("rst_loading", 32'(ld_f | ld_s), 0);
        check("rst_ready", 32'(bus_f.data_ready | bus_s.data_ready), 0);
        check("rst_wr", 32'(bus_f.mem_wr | bus_s.mem_wr), 0);
        check("rst_wc", 32'(wc_f), 0);
        reset = 1'b0;
        @(negedge clk);

        // Reset in the middle of a session
        pulse_start();
        check("load_ready", 32'(rdy), 1);
        for (int i = 0; i < 5; i++) send(8'(8'h50 + i), 1'b1);
        idle();
        check("mid_wc", 32'(wc_f), 5);
        reset = 1'b1;
        #1;
        check("midrst_wc", 32'(wc_f), 0);
        check("midrst_addr", 32'(bus_f.mem_address), 0);
        check("midrst_data", 32'(bus_f.mem_data), 0);
        check("midrst_loading", 32'(ld_f), 0);
        check("midrst_ready", 32'(bus_f.data_ready), 0);
        @(negedge clk);
        reset = 1'b0;
        cnt_f = 0;
        @(negedge clk);

        // Full 16-word load with continuous valid
        pulse_start();
        check("full_loading", 32'(ld_f), 1);
        check("full_wc0", 32'(wc_f), 0);
        for (int i = 0; i < LEN_F; i++) send(8'(8'h10 + i), 1'b1);
        finish_load(8'h78, LEN_F);

        // Valid data and start while running are ignored
        dv = 1'b1; din = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        dv = 1'b0;
        check("ign_done", 32'(dn_f), 1);
        check("ign_wc", 32'(wc_f), LEN_F);
        check("ign_loading", 32'(ld_f), 0);

        // Gapped 4-word load on the short instance
        sel = 1'b1;
        pulse_start();
        send(8'hA1, 1'b1);
        start = 1'b1; halt = 1'b1;
        @(negedge clk);
        start = 1'b0; halt = 1'b0;
        check("gap_no_restart_wc", 32'(wc_s), 1);
        check("gap_still_loading", 32'(ld_s), 1);
        send(8'hA2, 1'b1);
        idle();
        send(8'hA3, 1'b1);
        idle();
        send(8'hA4, 1'b1);
        finish_load(8'h8A, LEN_S);

        // Halt with simultaneous start, then reload
        halt = 1'b1; start = 1'b1;
        @(negedge clk);
        halt = 1'b0; start = 1'b0;
        check("halt_op", 32'(op_s), 0);
        check("halt_done", 32'(dn_s), 0);
        check("halt_loading", 32'(ld_s), 0);
        @(negedge clk);
        check("halt_start_ignored", 32'(ld_s), 0);
        cnt_s = 0;
        pulse_start();
        check("reload_loading", 32'(ld_s), 1);
        check("reload_wc0", 32'(wc_s), 0);
        for (int i = 1; i <= LEN_S; i++) send(8'(i), 1'b1);
        finish_load(8'h0A, LEN_S);

`ifdef LOADER_CHECKSUM_EN
        // Bad checksum returns to IDLE with the error flag up
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        cnt_s = 0;
        pulse_start();
        for (int i = 1; i <= LEN_S; i++) send(8'(i), 1'b1);
        send(8'h0B, 1'b0);
        check("bad_cksum_err", 32'(ce_s), 1);
        check("bad_cksum_op", 32'(op_s), 0);
        check("bad_cksum_done", 32'(dn_s), 0);
        check("bad_cksum_loading", 32'(ld_s), 0);
        pulse_start();
        check("cksum_err_cleared", 32'(ce_s), 0);
        check("cksum_restart", 32'(ld_s), 1);
`endif

        repeat (2) @(negedge clk);
        check("full_queue_empty", q_f.size(), 0);
        check("short_queue_empty", q_s.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
